// File: rtl/led_pattern_monitor.sv
// Receive-side checker for the 41-step 12-LED chaser: locks on 000->001, predicts, flags and counts deviations.
// Latency: all outputs registered, visible the cycle after the clk edge that samples step=1.
// No backpressure: samples on every step pulse, back-to-back steps supported.
module led_pattern_monitor #(
   parameter int ERR_W = 8,
   parameter int CYC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  logic [11:0]      led_in,
   input  logic             clr,
   output logic             locked,
   output logic [2:0]       phase,
   output logic             err,
   output logic [ERR_W-1:0] err_count,
   output logic [CYC_W-1:0] cyc_count
);

   typedef enum logic {HUNT, TRACK} state_t;

   state_t           state, state_nx;
   logic [5:0]       idx, idx_nx, nidx;
   logic [11:0]      prev, prev_nx;
   logic [2:0]       phase_nx;
   logic             err_nx, lock_hit;
   logic [ERR_W-1:0] err_count_nx;
   logic [CYC_W-1:0] cyc_count_nx;

   // Expected LED word at each position of the chaser period.
   function automatic logic [11:0] exp_word(input logic [5:0] i);
      case (i)
         6'd0:  exp_word = 12'h001;  6'd1:  exp_word = 12'h003;
         6'd2:  exp_word = 12'h007;  6'd3:  exp_word = 12'h00F;
         6'd4:  exp_word = 12'h01F;  6'd5:  exp_word = 12'h03F;
         6'd6:  exp_word = 12'h07F;  6'd7:  exp_word = 12'h0FF;
         6'd8:  exp_word = 12'h1FF;  6'd9:  exp_word = 12'h3FF;
         6'd10: exp_word = 12'h7FF;  6'd11: exp_word = 12'hFFF;
         6'd12: exp_word = 12'h000;
         6'd13: exp_word = 12'h800;  6'd14: exp_word = 12'hC00;
         6'd15: exp_word = 12'hE00;  6'd16: exp_word = 12'hF00;
         6'd17: exp_word = 12'hF80;  6'd18: exp_word = 12'hFC0;
         6'd19: exp_word = 12'hFE0;  6'd20: exp_word = 12'hFF0;
         6'd21: exp_word = 12'hFF8;  6'd22: exp_word = 12'hFFC;
         6'd23: exp_word = 12'hFFE;  6'd24: exp_word = 12'hFFF;
         6'd25: exp_word = 12'h000;
         6'd26: exp_word = 12'h801;  6'd27: exp_word = 12'hC03;
         6'd28: exp_word = 12'hE07;  6'd29: exp_word = 12'hF0F;
         6'd30: exp_word = 12'hF9F;  6'd31: exp_word = 12'hFFF;
         6'd32: exp_word = 12'h000;
         6'd33: exp_word = 12'h060;  6'd34: exp_word = 12'h0F0;
         6'd35: exp_word = 12'h1F8;  6'd36: exp_word = 12'h3FC;
         6'd37: exp_word = 12'h7FE;  6'd38: exp_word = 12'hFFF;
         default: exp_word = 12'h000;
      endcase
   endfunction

   // Sub-pattern code for a sequence position; blanks (and out-of-range) map to 5.
   function automatic logic [2:0] exp_phase(input logic [5:0] i);
      if (i <= 6'd11)                      exp_phase = 3'd1;
      else if (i >= 6'd13 && i <= 6'd24)   exp_phase = 3'd2;
      else if (i >= 6'd26 && i <= 6'd31)   exp_phase = 3'd3;
      else if (i >= 6'd33 && i <= 6'd38)   exp_phase = 3'd4;
      else                                 exp_phase = 3'd5;
   endfunction

   assign nidx     = (idx == 6'd40) ? 6'd0 : idx + 6'd1;
   assign lock_hit = (prev == 12'h000) && (led_in == 12'h001);

   // Next-state: hunt for 000->001, track and compare, count, clear.
   always_comb begin
      state_nx     = state;
      idx_nx       = idx;
      prev_nx      = prev;
      err_nx       = 1'b0;
      err_count_nx = err_count;
      cyc_count_nx = cyc_count;
      if (step) begin
         prev_nx = led_in;
         if (state == HUNT) begin
            if (lock_hit) begin
               state_nx = TRACK;
               idx_nx   = 6'd0;
            end
         end else if (led_in == exp_word(nidx)) begin
            idx_nx = nidx;
            if (nidx == 6'd0)
               cyc_count_nx = cyc_count + CYC_W'(1);
         end else begin
            // A mismatch that is itself a valid lock pair relocks at once.
            err_nx   = 1'b1;
            state_nx = lock_hit ? TRACK : HUNT;
            idx_nx   = 6'd0;
            if (err_count != {ERR_W{1'b1}})
               err_count_nx = err_count + ERR_W'(1);
         end
      end
      if (clr) begin
         err_count_nx = '0;
         cyc_count_nx = '0;
      end
      phase_nx = (state_nx == TRACK) ? exp_phase(idx_nx) : 3'd0;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= HUNT;
         idx       <= 6'd0;
         prev      <= 12'h000;
         phase     <= 3'd0;
         err       <= 1'b0;
         err_count <= '0;
         cyc_count <= '0;
      end else begin
         state     <= state_nx;
         idx       <= idx_nx;
         prev      <= prev_nx;
         phase     <= phase_nx;
         err       <= err_nx;
         err_count <= err_count_nx;
         cyc_count <= cyc_count_nx;
      end
   end

   assign locked = (state == TRACK);

endmodule

// File: doc/led_pattern_monitor.md
# led_pattern_monitor

Receive-side checker for the 12-LED chaser pattern bus. Samples the 12-bit LED word once per producer step and locks onto the fixed 41-step chaser sequence. Once locked, it predicts every following word and reports the current phase. It flags and counts deviations and counts completed periods. Sits beside the LED driver on the board, or in the bench, as a self-check on the pattern output.

## Interface
Parameters:
- ERR_W, 8, width of saturating error counter
- CYC_W, 16, width of wrapping period counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- step  in  1  one-clk pulse per producer update; led_in is stable and valid while high
- led_in  in  12  LED word from the producer, already synchronous to clk
- clr  in  1  synchronous clear of err_count and cyc_count
- locked  out  1  monitor is tracking the sequence
- phase  out  3  0 = unlocked, 1 = fill-right, 2 = fill-left, 3 = fill-both-ends, 4 = centre-out, 5 = blank
- err  out  1  one-clk pulse on a mismatching sample while locked
- err_count  out  ERR_W  mismatches since reset/clr, saturates at all-ones
- cyc_count  out  CYC_W  completed periods, wraps to 0

## Operation
- Expected sequence E[idx], idx 0..40, all hex:
  - 0–11: 001,003,007,00F,01F,03F,07F,0FF,1FF,3FF,7FF,FFF, phase 1
  - 12: 000, phase 5
  - 13–24: 800,C00,E00,F00,F80,FC0,FE0,FF0,FF8,FFC,FFE,FFF, phase 2
  - 25: 000, phase 5
  - 26–31: 801,C03,E07,F0F,F9F,FFF, phase 3
  - 32: 000, phase 5
  - 33–38: 060,0F0,1F8,3FC,7FE,FFF, phase 4
  - 39, 40: 000,000, phase 5
- Internal registers:
  - prev[11:0]: last sampled word. Updated on every step, locked or not.
  - idx[5:0]: position in E.
- States: HUNT and TRACK.
- HUNT, on step:
  - If prev==000 and led_in==001, go to TRACK with idx=0.
  - Otherwise stay in HUNT. No err is raised in HUNT.
- TRACK, on step: nidx = (idx==40) ? 0 : idx+1.
  - If led_in==E[nidx], set idx=nidx.
  - If in addition nidx==0, increment cyc_count (wrapping).
  - On mismatch: pulse err, increment err_count (saturating), go to HUNT.
  - In the same step, apply the HUNT lock test to (prev, led_in). A valid 000→001 relocks immediately with idx=0 and locked stays 1. err still pulses.
- Outputs:
  - locked = (state==TRACK).
  - phase = E-phase of idx when locked, else 0.
- clr while step: clr wins. Counters go to 0 and that step's increments are discarded. err still pulses and state/idx still update.
- Cycles with step low change nothing except clr.

## Timing
- Reset (rst low, async) values:
  - Outputs: locked=0, phase=0, err=0, err_count=0, cyc_count=0.
  - Internal: state=HUNT, prev=000, idx=0.
  - The producer's post-reset 000 followed by 001 therefore locks on the first step.
- All outputs are registered. Their effect appears on the clk edge that samples step=1 and is visible the following cycle.
- err is high for exactly one cycle per mismatch.
- No minimum step spacing: back-to-back steps on consecutive clocks are supported.
- Reset mid-sequence returns to HUNT immediately. Relock requires a fresh 000→001 pair.

## Test plan
- Reset, then drive 3 full periods (000 then 123 steps from E[0]), steps spaced 5 clk apart. Required: locked=1 after first 001; phase follows 1,5,2,5,3,5,4,5; err never 1; cyc_count=2 with the third period ending at idx 40.
- While locked at idx 27 (C03), drive F00. Required: one-cycle err, err_count=1, locked=0, phase=0. Then feed 000, 001: relock, phase=1.
- While locked, corrupt idx 12 (000 → 001). prev=FFF, so no relock occurs. Required: err, locked=0. A subsequent 000, 001 relocks.
- Force 300 mismatches (alternate 000/001/FFF patterns). Required: err_count holds 255 and does not wrap.
- Assert clr with step on a mismatching sample. Required: err pulses, err_count=0, cyc_count=0.
- Assert rst mid-phase-3 with steps on consecutive clocks. Required: all outputs 0 asynchronously; resumed sequence from idx 28 never locks until the next 000→001.
